// File: rtl/sensor_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// sensor_pattern_gen_if
// Parallel pixel bus as presented by an image sensor: a frame strobe, a line
// strobe and pixel data. The generator drives it through the master modport.
// The capture path observes it through the slave modport.
//   frame_valid : high from frame start to frame end
//   line_valid  : high during active pixels
//   pix_data    : pixel value, zero whenever line_valid is low
// ---------------------------------------------------------------------------
interface sensor_pattern_gen_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  frame_valid;
  logic                  line_valid;
  logic [DATA_WIDTH-1:0] pix_data;

  modport master (output frame_valid, output line_valid, output pix_data);
  modport slave  (input  frame_valid, input  line_valid, input  pix_data);
endinterface

// File: rtl/sensor_pattern_gen.sv
// ---------------------------------------------------------------------------
// sensor_pattern_gen
// Synthetic image-sensor source in the pixel clock domain. It produces frames
// with programmable geometry, blanking and test pattern on the same parallel
// pixel bus that a real sensor drives.
//   clk         : pixel clock; all logic runs on the rising edge
//   reset       : synchronous, active-high
//   enable      : 1 = run frames back to back; 0 = stop once the current
//                 frame (including vertical blanking) has finished
//   width       : active pixels per line            (0 behaves as 1)
//   height      : active lines per frame            (0 behaves as 1)
//   hblank      : horizontal blanking cycles        (0 behaves as 1)
//   vblank      : vertical blanking cycles          (0 behaves as 1)
//   pattern     : 0 = x, 1 = y, 2 = 8x8 checkerboard, 3 = x+y+frame_count
//   pix_if      : frame_valid / line_valid / pix_data (master)
//   frame_count : completed frames, wraps around
//   busy        : high while the generator is not idle
// Stage p0 holds the frame FSM and its counters. Stage p1 is the output
// register. Every output therefore trails the FSM state by one cycle.
// ---------------------------------------------------------------------------
module sensor_pattern_gen #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] width,
  input  logic [CNT_WIDTH-1:0] height,
  input  logic [CNT_WIDTH-1:0] hblank,
  input  logic [CNT_WIDTH-1:0] vblank,
  input  logic [1:0]           pattern,
  sensor_pattern_gen_if.master pix_if,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic                 busy
);

  localparam int SUM_W = (DATA_WIDTH > CNT_WIDTH) ? DATA_WIDTH : CNT_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FSTART = 3'd1,
    LINE   = 3'd2,
    HBLANK = 3'd3,
    FEND   = 3'd4,
    VBLANK = 3'd5
  } state_t;

  // A zero-length line, frame or blanking interval is treated as length 1.
  // This keeps the "count == length-1" terminal compares well defined.
  function automatic logic [CNT_WIDTH-1:0] clamp1(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? CNT_WIDTH'(1) : v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pattern_pix(
    input logic [1:0]           sel,
    input logic [CNT_WIDTH-1:0] px,
    input logic [CNT_WIDTH-1:0] py,
    input logic [CNT_WIDTH-1:0] fc
  );
    logic [SUM_W-1:0] sum;
    case (sel)
      2'd0:    sum = SUM_W'(px);
      2'd1:    sum = SUM_W'(py);
      2'd2:    sum = (px[3] ^ py[3]) ? '1 : '0;
      default: sum = SUM_W'(px) + SUM_W'(py) + SUM_W'(fc);
    endcase
    return sum[DATA_WIDTH-1:0];
  endfunction

  state_t               state_p0, state_nxt;
  logic [CNT_WIDTH-1:0] x_p0, y_p0, cnt_p0, fcnt_p0;
  logic [CNT_WIDTH-1:0] w_p0, h_p0, hb_p0, vb_p0;
  logic [1:0]           pat_p0;

  logic [CNT_WIDTH-1:0] blank_len;
  logic                 cnt_last, x_last, y_last, enter_fstart;

  logic                  fv_p1, lv_p1, busy_p1;
  logic [DATA_WIDTH-1:0] pix_p1;
  logic [CNT_WIDTH-1:0]  fc_p1;

  // The same cnt_p0 times every blanking interval. Only VBLANK uses the
  // vertical length.
  assign blank_len = (state_p0 == VBLANK) ? vb_p0 : hb_p0;
  assign cnt_last  = (cnt_p0 == blank_len - 1'b1);
  assign x_last    = (x_p0 == w_p0 - 1'b1);
  assign y_last    = (y_p0 == h_p0 - 1'b1);

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:    if (enable)   state_nxt = FSTART;
      FSTART:  if (cnt_last) state_nxt = LINE;
      LINE:    if (x_last)   state_nxt = y_last ? FEND : HBLANK;
      HBLANK:  if (cnt_last) state_nxt = LINE;
      FEND:    if (cnt_last) state_nxt = VBLANK;
      VBLANK:  if (cnt_last) state_nxt = enable ? FSTART : IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  assign enter_fstart = (state_nxt == FSTART) && (state_p0 != FSTART);

  // ---- stage p0: frame FSM and counters ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      x_p0     <= '0;
      y_p0     <= '0;
      fcnt_p0  <= '0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= (state_nxt != state_p0) ? '0 : cnt_p0 + 1'b1;
      if (state_p0 == LINE && !x_last) x_p0 <= x_p0 + 1'b1;
      else                             x_p0 <= '0;
      if (enter_fstart)
        y_p0 <= '0;
      else if (state_p0 == LINE && x_last && !y_last)
        y_p0 <= y_p0 + 1'b1;
      if (state_p0 == FEND && state_nxt == VBLANK)
        fcnt_p0 <= fcnt_p0 + 1'b1;
    end
  end

  // The configuration is sampled only at frame entry. A frame therefore
  // always runs with consistent geometry, whatever the inputs do meanwhile.
  always_ff @(posedge clk) begin
    if (enter_fstart) begin
      w_p0   <= clamp1(width);
      h_p0   <= clamp1(height);
      hb_p0  <= clamp1(hblank);
      vb_p0  <= clamp1(vblank);
      pat_p0 <= pattern;
    end
  end

  // ---- stage p1: registered sensor outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      fv_p1   <= 1'b0;
      lv_p1   <= 1'b0;
      pix_p1  <= '0;
      fc_p1   <= '0;
      busy_p1 <= 1'b0;
    end else begin
      fv_p1   <= (state_p0 == FSTART) || (state_p0 == LINE) ||
                 (state_p0 == HBLANK) || (state_p0 == FEND);
      lv_p1   <= (state_p0 == LINE);
      pix_p1  <= (state_p0 == LINE) ? pattern_pix(pat_p0, x_p0, y_p0, fcnt_p0) : '0;
      fc_p1   <= fcnt_p0;
      busy_p1 <= (state_p0 != IDLE);
    end
  end

  assign pix_if.frame_valid = fv_p1;
  assign pix_if.line_valid  = lv_p1;
  assign pix_if.pix_data    = pix_p1;
  assign frame_count        = fc_p1;
  assign busy               = busy_p1;

endmodule

// File: doc/sensor_pattern_gen.md
# sensor_pattern_gen

Synthetic image-sensor source that drives the same parallel pixel interface the capture path receives from the sensor: frame valid, line valid and pixel data, with programmable geometry, blanking and test pattern. It sits in the pixel clock domain in place of, or beside, the real sensor inputs. It provides a deterministic stimulus for the capture/FIFO/DDR path without a sensor attached, and serves as the model the capture path is verified against.

## Interface
- DATA_WIDTH, 12, pixel data width (sensor bit depth)
- CNT_WIDTH, 16, width of geometry/blanking counters and config inputs
- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  1 = generate frames continuously; 0 = stop after current frame
- width  in  CNT_WIDTH  active pixels per line
- height  in  CNT_WIDTH  active lines per frame
- hblank  in  CNT_WIDTH  horizontal blanking cycles
- vblank  in  CNT_WIDTH  vertical blanking cycles (frame_valid low)
- pattern  in  2  pattern select
- frame_valid  out  1  high from frame start to frame end
- line_valid  out  1  high during active pixels
- pix_data  out  DATA_WIDTH  pixel value; 0 whenever line_valid=0
- frame_count  out  CNT_WIDTH  completed frames, wraps modulo 2^CNT_WIDTH
- busy  out  1  high in any state other than IDLE

## Operation
- States:
  - IDLE: all strobes low.
  - FSTART: frame_valid=1, line_valid=0, lasts hblank cycles.
  - LINE: frame_valid=1, line_valid=1, lasts width cycles.
  - HBLANK: frame_valid=1, line_valid=0, lasts hblank cycles.
  - FEND: frame_valid=1, line_valid=0, lasts hblank cycles.
  - VBLANK: frame_valid=0, lasts vblank cycles.
- Transitions:
  - IDLE→FSTART when enable=1.
  - FSTART→LINE.
  - LINE→HBLANK if the line index is below height-1, else LINE→FEND.
  - HBLANK→LINE.
  - FEND→VBLANK.
  - VBLANK→FSTART if enable=1, else VBLANK→IDLE.
- Configuration latching:
  - width, height, hblank, vblank and pattern are latched on entry to FSTART.
  - Changes mid-frame take effect at the next frame.
  - A latched value of 0 is clamped to 1 for all four geometry/blanking values.
- Counters: x (0..width-1) within a line; y (0..height-1) within a frame. Both reset to 0 on FSTART.
- Patterns (result truncated to DATA_WIDTH LSBs):
  - 0: x
  - 1: y
  - 2: all-ones if x[3]^y[3], else 0 (8×8 checkerboard)
  - 3: x+y+frame_count
- frame_count increments by 1 on the FEND→VBLANK transition.
- enable deasserted mid-frame: the current frame completes, including VBLANK, then the block enters IDLE. A frame is never truncated.
- Reset: all state and outputs go to 0 on the next edge, at any point, including mid-line.

## Timing
- Reset values:
  - frame_valid=0, line_valid=0, pix_data=0, frame_count=0, busy=0.
  - state=IDLE, x=y=0.
- All outputs are registered; the strobes and pix_data are mutually aligned.
- Startup latency: enable sampled high at edge N → state=FSTART after edge N. frame_valid and busy are first high in the cycle after edge N+1. One cycle of output register latency applies throughout.
- Per frame, with W, H, HB, VB the clamped values:
  - frame_valid high for H·W + (H+1)·HB cycles.
  - frame_valid low for VB cycles.
  - period = H·W + (H+1)·HB + VB cycles.
- Each line_valid pulse is exactly W cycles; there are exactly H pulses per frame.
- frame_valid rises HB cycles before the first line_valid and falls HB cycles after the last.
- frame_count updates on the same edge that frame_valid deasserts, as seen at the output.
- Counter arithmetic: counters are CNT_WIDTH bits and compare against value-1. There is no overflow for any programmed value ≤ 2^CNT_WIDTH−1.

## Test plan
- W=4, H=2, HB=2, VB=3, pattern 0, enable held high:
  - Waveform: FV high 14 cycles, LV 4-high/2-low/4-high, FV low 3 cycles.
  - pix_data sequence 0,1,2,3 on each line; period 17.
- Pattern 2, W=16, H=16, HB=1, VB=1:
  - Line 0 data is 0×8 then 0xFFF×8.
  - Line 8 is inverted.
- Pattern 3, W=1, H=1, HB=1, VB=1, enable held for 5 frames:
  - pix_data = 0,1,2,3,4 per frame.
  - frame_count = 5 after the fifth FV fall.
- enable dropped during line 1 of a W=4, H=4 frame:
  - All 4 lines complete and VBLANK runs.
  - Then busy=0 and FV stays low.
  - enable re-raised → new frame after the 2-cycle latency.
- Zero config (all four = 0):
  - Behaves as 1: period 1+2+1 = 4 cycles.
  - LV pulses 1 cycle; pix_data=0 under pattern 0.
- reset asserted mid-LINE:
  - Next cycle FV=LV=0, pix_data=0, frame_count=0, busy=0.
  - With enable high after reset release, a full new frame starts at y=0, x=0.
